// File: rtl/aes_enc_round_sched.sv
// Iterative AES-128 encryption scheduler: one plaintext block in, initial
// AddRoundKey on accept, then ten rounds through one shared round datapath
// at one round per cycle. Round keys come from an external store by index.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE; the
// block holds out_valid/out_block stable until out_ready, and never looks at
// in_valid while busy. in_ready, rk_idx and busy decode from state only.
module aes_enc_round_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;
    // State matrix: element [c][r] holds s(r,c) = FIPS byte 4c+r.
    typedef logic [3:0][3:0][7:0] aes_state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t       state, state_nx;
    aes_state_t st;
    aes_state_t init_st, sb_st, sr_st, mc_st, round_nx;
    logic [3:0] rnd;
    logic       out_valid_q;
    logic       accept;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t to_state(input logic [127:0] b);
        aes_state_t s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = b[127 - 8 * (4 * c + r) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(input aes_state_t s);
        logic [127:0] b;
        b = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[127 - 8 * (4 * c + r) -: 8] = s[c][r];
        return b;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t m;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c][0];
            a1 = s[c][1];
            a2 = s[c][2];
            a3 = s[c][3];
            m[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            m[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            m[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            m[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return m;
    endfunction

    assign accept = in_valid && in_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_ROUND;
            S_ROUND: if (rnd == LAST_ROUND) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM output decode: state and counter only, never inputs
    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
        rk_idx   = (state == S_ROUND) ? rnd : 4'd0;
    end

    // Round datapath: SubBytes, ShiftRows, MixColumns (skipped in round 10), AddRoundKey
    always_comb begin
        init_st = to_state(in_block ^ rk_data);
        sb_st   = '0;
        sr_st   = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sb_st[c][r] = sbox(st[c][r]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr_st[c][r] = sb_st[(c + r) % 4][r];
        mc_st    = mix_columns(sr_st);
        round_nx = ((rnd == LAST_ROUND) ? sr_st : mc_st) ^ to_state(rk_data);
    end

    // State matrix, round counter and registered out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= '0;
            rnd         <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        st  <= init_st;
                        rnd <= 4'd1;
                    end
                end
                S_ROUND: begin
                    st <= round_nx;
                    if (rnd != LAST_ROUND) rnd <= rnd + 4'd1;
                end
                S_DONE: begin
                    if (out_ready) rnd <= 4'd0;
                end
                default: rnd <= 4'd0;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_block = from_state(st);

endmodule

// File: tb/tb_aes_enc_round_sched.sv
// Bench for aes_enc_round_sched: FIPS/known-answer table, per-cycle round
// trace against a reference model, back-pressure, input-while-busy and
// mid-round reset sequences, with a ciphertext scoreboard.
module tb_aes_enc_round_sched;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  aes_enc_round_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb_t[256];
  logic [1407:0] rk_all;
  vec_t         vecs[5];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // round-key store: combinational read by index
  always_comb begin
    if (int'(rk_idx) <= 10) rk_data = rk_all[int'(rk_idx) * 128 +: 128];
    else                    rk_data = '0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    res = '0;
    for (int i = 0; i < 11; i++) res[i * 128 +: 128] = {w[4 * i], w[4 * i + 1], w[4 * i + 2], w[4 * i + 3]};
    return res;
  endfunction

  // state after AddRoundKey of round nr (nr = 0: initial AddRoundKey only)
  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt, input int nr);
    logic [1407:0] ks;
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    ks = key_expand(key);
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ ks[127 - 8 * k -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sb_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4 * c + r] = s[4 * ((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (rnd < 10) begin
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[rnd * 128 + 127 - 8 * k -: 8];
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
    return res;
  endfunction

  // scoreboard: pop one expected ciphertext per output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_with_empty_queue", 128'(exp_q.size() + 1), 128'd0);
      else chk("ciphertext", out_block, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] exp_ct);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_block = pt;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (in_ready) begin
      chk("rk_idx_at_accept", 128'(rk_idx), 128'd0);
      exp_q.push_back(exp_ct);
      tick();
    end else begin
      chk("accept_timeout", 128'(in_ready), 128'd1);
    end
    in_valid = 1'b0;
  endtask

  // called in cycle T+1; returns the cycle offset where out_valid was first seen
  task automatic wait_out(output int cyc, input logic [127:0] key, input logic [127:0] pt, input bit trace);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (trace) begin
        chk("rk_idx_round", 128'(rk_idx), 128'(cyc));
        chk("busy_round", 128'(busy), 128'd1);
        chk("round_state", out_block, aes_model(key, pt, cyc - 1));
      end
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int seen;
    logic [127:0] hold;
    logic [127:0] pt;
    logic [127:0] pe;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_block = '0;
    out_ready = 1'b1;
    rk_all = '0;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 3; i < 5; i++) begin
      vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct  = aes_model(vecs[i].key, vecs[i].pt, 10);
    end

    // reset values
    #12;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_rk_idx", 128'(rk_idx), 128'd0);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out_block", out_block, 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // table-driven known-answer vectors with per-round trace
    for (int i = 0; i < 5; i++) begin
      rk_all = key_expand(vecs[i].key);
      repeat ($urandom_range(0, 3)) tick();
      send_block(vecs[i].pt, vecs[i].ct);
      wait_out(cyc, vecs[i].key, vecs[i].pt, 1'b1);
      chk("latency", 128'(cyc), 128'd11);
      chk("done_in_ready", 128'(in_ready), 128'd0);
      tick();
      chk("ii_in_ready", 128'(in_ready), 128'd1);
      chk("ii_busy", 128'(busy), 128'd0);
    end

    // back-pressure: out_ready low for 5 cycles after out_valid rises
    rk_all = key_expand(vecs[2].key);
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    out_ready = 1'b0;
    send_block(pt, aes_model(vecs[2].key, pt, 10));
    wait_out(cyc, vecs[2].key, pt, 1'b0);
    chk("bp_latency", 128'(cyc), 128'd11);
    hold = out_block;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_block", out_block, hold);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);

    // second block offered from T+1 while the first is in flight
    rk_all = key_expand(vecs[0].key);
    send_block(vecs[0].pt, vecs[0].ct);
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    pe = aes_model(vecs[0].key, pt, 10);
    in_valid = 1'b1;
    in_block = pt;
    cyc = 1;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("busy_accept_cycle", 128'(cyc), 128'd12);
    if (in_ready) begin
      exp_q.push_back(pe);
      tick();
      in_valid = 1'b0;
      wait_out(cyc, vecs[0].key, pt, 1'b0);
      chk("second_latency", 128'(cyc), 128'd11);
      tick();
    end else begin
      in_valid = 1'b0;
    end

    // asynchronous reset during round 5
    rk_all = key_expand(vecs[1].key);
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(pt, aes_model(vecs[1].key, pt, 10));
    repeat (4) tick();
    chk("pre_reset_round", 128'(rk_idx), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    exp_q.delete();
    repeat (2) tick();
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("no_output_after_reset", 128'(seen), 128'd0);
    send_block(vecs[1].pt, vecs[1].ct);
    wait_out(cyc, vecs[1].key, vecs[1].pt, 1'b1);
    chk("post_reset_latency", 128'(cyc), 128'd11);
    repeat (2) tick();

    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
